// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter between a CPU and a host/loader requester
// for a byte-wide data memory. Each granted request moves one 32-bit word as
// four big-endian byte beats; accesses that would run past the end of the
// memory complete immediately with an error and never touch the memory.
module dmem_arbiter #(
    parameter int DEPTH  = 76,
    parameter int ADDR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [31:0]       cpu_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic              host_ack,
    output logic              host_err,
    output logic [31:0]       host_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ACK} state_t;

    // Memory size at the widened compare width, so addr+3 never wraps.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic              last_host;   // 1: host received the most recent grant
    logic              sel_host;    // requester owning the current transaction
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [1:0]        beat;
    logic [23:0]       rbuf;        // read bytes 0..2; byte 3 comes straight from memory

    logic              grant_any;
    logic              grant_host;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [ADDR_W:0]   req_end;
    logic              req_err;
    logic [1:0]        next_beat;

    // Big-endian byte lane select: beat 0 carries bits 31:24.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] b);
        logic [7:0] r;
        case (b)
            2'd0:    r = w[31:24];
            2'd1:    r = w[23:16];
            2'd2:    r = w[15:8];
            default: r = w[7:0];
        endcase
        return r;
    endfunction

    // Round-robin grant decision and range check of the candidate request.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        grant_any  = cpu_req | host_req;
        grant_host = host_req & (~cpu_req | ~last_host);
        req_we     = grant_host ? host_we    : cpu_we;
        req_addr   = grant_host ? host_addr  : cpu_addr;
        req_wdata  = grant_host ? host_wdata : cpu_wdata;
        req_end    = {1'b0, req_addr} + (ADDR_W + 1)'(3);
        req_err    = (req_end >= DEPTH_W);
        next_beat  = beat + 2'd1;
    end

    assign busy = (state != IDLE);

    // Arbiter FSM with registered memory-side and requester-side outputs.
    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            // NOTE: reset is synchronous; it clears every register including the read buffer.
            state      <= IDLE;
            last_host  <= 1'b1;
            sel_host   <= 1'b0;
            cur_we     <= 1'b0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            beat       <= '0;
            rbuf       <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        sel_host  <= grant_host;
                        last_host <= grant_host;
                        cur_we    <= req_we;
                        cur_addr  <= req_addr;
                        cur_wdata <= req_wdata;
                        if (req_err) begin
                            state <= ACK;
                            if (grant_host) begin
                                host_ack   <= 1'b1;
                                host_err   <= 1'b1;
                                host_rdata <= '0;
                            end else begin
                                cpu_ack    <= 1'b1;
                                cpu_err    <= 1'b1;
                                cpu_rdata  <= '0;
                            end
                        end else begin
                            state     <= ISSUE;
                            beat      <= 2'd0;
                            mem_en    <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_we ? word_byte(req_wdata, 2'd0) : 8'h00;
                        end
                    end
                end

                ISSUE: begin
                    // Memory data for the previous beat is valid during this one.
                    if (!cur_we) begin
                        case (beat)
                            2'd1:    rbuf[23:16] <= mem_rdata;
                            2'd2:    rbuf[15:8]  <= mem_rdata;
                            2'd3:    rbuf[7:0]   <= mem_rdata;
                            default: ;
                        endcase
                    end
                    if (beat == 2'd3) begin
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (cur_we) begin
                            state <= ACK;
                            if (sel_host) begin
                                host_ack   <= 1'b1;
                                host_err   <= 1'b0;
                                host_rdata <= '0;
                            end else begin
                                cpu_ack    <= 1'b1;
                                cpu_err    <= 1'b0;
                                cpu_rdata  <= '0;
                            end
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        beat      <= next_beat;
                        mem_addr  <= cur_addr + ADDR_W'(next_beat);
                        mem_wdata <= cur_we ? word_byte(cur_wdata, next_beat) : 8'h00;
                    end
                end

                DRAIN: begin
                    // Last read byte arrives now and goes straight to the requester.
                    state <= ACK;
                    if (sel_host) begin
                        host_ack   <= 1'b1;
                        host_err   <= 1'b0;
                        host_rdata <= {rbuf, mem_rdata};
                    end else begin
                        cpu_ack    <= 1'b1;
                        cpu_err    <= 1'b0;
                        cpu_rdata  <= {rbuf, mem_rdata};
                    end
                end

                ACK: begin
                    state      <= IDLE;
                    cpu_ack    <= 1'b0;
                    cpu_err    <= 1'b0;
                    cpu_rdata  <= '0;
                    host_ack   <= 1'b0;
                    host_err   <= 1'b0;
                    host_rdata <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed boundary cases plus randomized
// two-requester traffic, with a byte-array reference model and per-requester
// expected-response queues checked by an independent ack monitor.
module tb_dmem_arbiter;

    localparam int DEPTH  = 76;
    localparam int ADDR_W = 8;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we, host_req, host_we;
    logic [ADDR_W-1:0] cpu_addr, host_addr;
    logic [31:0]       cpu_wdata, host_wdata;
    logic              cpu_ack, cpu_err, host_ack, host_err;
    logic [31:0]       cpu_rdata, host_rdata;
    logic              mem_en, mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;

    dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       exp_cpu[$];
    exp_t       exp_host[$];
    logic [7:0] ref_mem [0:DEPTH-1];   // reference model contents
    logic [7:0] mem     [0:DEPTH-1];   // memory attached to the DUT
    int         checks = 0;
    int         errors = 0;
    int         viol   = 0;
    int         cyc    = 0;
    int         mem_beats = 0;
    logic       prev_cpu_ack = 1'b0, prev_host_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte memory: one-cycle read latency, write on enabled write beats.
    always @(posedge CLOCK_50) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            mem_beats <= mem_beats + 1;
            if (int'(mem_addr) < DEPTH) begin
                if (mem_we) mem[mem_addr] <= mem_wdata;
                else        mem_rdata     <= mem[mem_addr];
            end
        end
    end

    // Monitor: pops the expected response whenever a requester is acked.
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            exp_t e;
            if (cpu_ack) begin
                if (exp_cpu.size() == 0) check("cpu_unexpected_ack", 1, 0);
                else begin
                    e = exp_cpu.pop_front();
                    check("cpu_rdata", cpu_rdata, e.rdata);
                    check("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
                end
            end
            if (host_ack) begin
                if (exp_host.size() == 0) check("host_unexpected_ack", 1, 0);
                else begin
                    e = exp_host.pop_front();
                    check("host_rdata", host_rdata, e.rdata);
                    check("host_err", {31'd0, host_err}, {31'd0, e.err});
                end
            end
            if (cpu_ack && host_ack)                   viol++;
            if ((cpu_ack && prev_cpu_ack) || (host_ack && prev_host_ack)) viol++;
            if (mem_en && !busy)                       viol++;
            if (!mem_we && mem_wdata != 8'h00)         viol++;
            if (mem_en && int'(mem_addr) >= DEPTH)     viol++;
            prev_cpu_ack  = cpu_ack;
            prev_host_ack = host_ack;
        end
    end

    // Reference model: compute the response from the word-level rules.
    task automatic push_exp(input bit who, input bit we, input logic [7:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   a = int'(addr);
        e.err   = (a + 3 >= DEPTH);
        e.rdata = 32'd0;
        if (!e.err) begin
            if (we) begin
                ref_mem[a]   = wdata[31:24];
                ref_mem[a+1] = wdata[23:16];
                ref_mem[a+2] = wdata[15:8];
                ref_mem[a+3] = wdata[7:0];
            end else begin
                e.rdata = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
            end
        end
        if (who) exp_host.push_back(e);
        else     exp_cpu.push_back(e);
    endtask

    // One complete transaction; exp_lat < 0 skips the latency comparison.
    task automatic do_req(input bit who, input bit we, input logic [7:0] addr,
                          input logic [31:0] wdata, input int exp_lat);
        int  n = 0;
        bit  got = 0;
        @(negedge CLOCK_50);
        push_exp(who, we, addr, wdata);
        if (who) begin host_we = we; host_addr = addr; host_wdata = wdata; host_req = 1'b1; end
        else     begin cpu_we  = we; cpu_addr  = addr; cpu_wdata  = wdata; cpu_req  = 1'b1; end
        while (!got && n < 60) begin
            @(posedge CLOCK_50);
            n++;
            @(negedge CLOCK_50);
            got = who ? host_ack : cpu_ack;
        end
        if (who) host_req = 1'b0;
        else     cpu_req  = 1'b0;
        if (!got) check(who ? "host_ack_timeout" : "cpu_ack_timeout", 0, 1);
        else if (exp_lat >= 0) check(who ? "host_latency" : "cpu_latency", n, exp_lat);
    endtask

    task automatic random_traffic(input bit who, input int count);
        for (int i = 0; i < count; i++) begin
            bit          we = 1'($urandom_range(0, 1));
            logic [7:0]  a  = who ? 8'($urandom_range(36, 100)) : 8'($urandom_range(0, 32));
            logic [31:0] d  = $urandom;
            repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
            do_req(who, we, a, d, -1);
        end
    endtask

    initial begin
        int order[$];
        int times[$];
        int base;
        bit seen;

        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 8'h00;
            mem[i]     = 8'h00;
        end

        // Both requesters held high through reset: alternating grants, cpu first.
        reset = 1'b1;
        cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 8'd0;   cpu_wdata = '0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'd40; host_wdata = '0;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_mem_en", {31'd0, mem_en}, 0);
        check("rst_mem_we", {31'd0, mem_we}, 0);
        check("rst_mem_addr", {24'd0, mem_addr}, 0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 0);
        check("rst_cpu_ack", {31'd0, cpu_ack}, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_host_ack", {31'd0, host_ack}, 0);
        check("rst_host_err", {31'd0, host_err}, 0);
        push_exp(0, 0, 8'd0, 0);  push_exp(1, 0, 8'd40, 0);
        push_exp(0, 0, 8'd0, 0);  push_exp(1, 0, 8'd40, 0);
        reset = 1'b0;
        for (int k = 0; k < 80 && order.size() < 4; k++) begin
            @(negedge CLOCK_50);
            if (cpu_ack)  begin order.push_back(0); times.push_back(cyc); end
            if (host_ack) begin order.push_back(1); times.push_back(cyc); end
        end
        cpu_req = 1'b0;
        host_req = 1'b0;
        check("rr_grant_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) check("rr_grant_order", order[i], i % 2);
        for (int i = 1; i < times.size(); i++) check("rr_ack_spacing", times[i] - times[i-1], 7);
        repeat (2) @(negedge CLOCK_50);

        // CPU word write then read back.
        do_req(0, 1, 8'd8, 32'h11223344, 5);
        check("mem8",  {24'd0, mem[8]},  32'h11);
        check("mem9",  {24'd0, mem[9]},  32'h22);
        check("mem10", {24'd0, mem[10]}, 32'h33);
        check("mem11", {24'd0, mem[11]}, 32'h44);
        do_req(0, 0, 8'd8, 0, 6);

        // Range boundary: 73 errors without a memory beat, 72 is the last legal word.
        base = mem_beats;
        do_req(1, 0, 8'd73, 0, 1);
        check("err_no_mem_beat", mem_beats - base, 0);
        base = mem_beats;
        do_req(0, 0, 8'd255, 0, 1);
        check("wrap_no_mem_beat", mem_beats - base, 0);
        do_req(1, 1, 8'd72, 32'hA1B2C3D4, 5);
        check("mem72", {24'd0, mem[72]}, 32'hA1);
        check("mem75", {24'd0, mem[75]}, 32'hD4);
        do_req(1, 0, 8'd72, 0, 6);
        do_req(0, 0, 8'd9, 0, 6);

        // Randomized concurrent traffic in disjoint address regions.
        fork
            random_traffic(0, 40);
            random_traffic(1, 40);
        join
        repeat (4) @(negedge CLOCK_50);
        check("cpu_queue_drained", exp_cpu.size(), 0);
        check("host_queue_drained", exp_host.size(), 0);

        // Reset during beat 2 of a write aborts it without an ack.
        @(negedge CLOCK_50);
        cpu_we = 1'b1; cpu_addr = 8'd20; cpu_wdata = 32'hDEADBEEF; cpu_req = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge CLOCK_50);
            seen = mem_en && (mem_addr == 8'd22);
        end
        check("abort_beat2_seen", {31'd0, seen}, 1);
        reset = 1'b1;
        cpu_req = 1'b0;
        @(negedge CLOCK_50);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_mem_en", {31'd0, mem_en}, 0);
        check("abort_cpu_ack", {31'd0, cpu_ack}, 0);
        reset = 1'b0;
        repeat (8) @(negedge CLOCK_50);
        do_req(0, 0, 8'd8, 0, 6);

        repeat (2) @(negedge CLOCK_50);
        check("protocol_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
